// File: rtl/match_len_extender_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// match_len_extender_if : start / segment / result handshakes of the extender
// Revision: 1.0
// ---------------------------------------------------------------------------
interface match_len_extender_if #(
  parameter int ID_WIDTH        = 6,
  parameter int SEG_LEN_WIDTH   = 5,
  parameter int MATCH_LEN_WIDTH = 9
);
  logic                       start_valid;
  logic                       start_ready;
  logic [ID_WIDTH-1:0]        start_id;
  logic                       seg_valid;
  logic                       seg_ready;
  logic [SEG_LEN_WIDTH-1:0]   seg_len;
  logic                       seg_can_ext;
  logic                       out_valid;
  logic                       out_ready;
  logic [ID_WIDTH-1:0]        out_id;
  logic [MATCH_LEN_WIDTH-1:0] out_match_len;

  modport master (
    output start_valid, start_id, seg_valid, seg_len, seg_can_ext, out_ready,
    input  start_ready, seg_ready, out_valid, out_id, out_match_len
  );

  modport slave (
    input  start_valid, start_id, seg_valid, seg_len, seg_can_ext, out_ready,
    output start_ready, seg_ready, out_valid, out_id, out_match_len
  );
endinterface
`default_nettype wire

// File: rtl/match_len_extender.sv
`default_nettype none
// ---------------------------------------------------------------------------
// match_len_extender : sums per-window match segments into a saturating total
// Optional abort input enabled by MATCH_LEN_EXT_ABORT_EN.  Revision: 1.0
// ---------------------------------------------------------------------------
module match_len_extender #(
  parameter int MASK_WIDTH      = 14,
  parameter int SEG_LEN_WIDTH   = 5,
  parameter int MAX_MATCH_LEN   = 258,
  parameter int MATCH_LEN_WIDTH = 9,
  parameter int ID_WIDTH        = 6
) (
  input  wire                  clk,
  input  wire                  rst_n,
`ifdef MATCH_LEN_EXT_ABORT_EN
  input  wire                  abort,
`endif
  match_len_extender_if.slave  bus
);

  if (SEG_LEN_WIDTH < $clog2(MASK_WIDTH + 1)) begin : g_seg_width_check
    $error("SEG_LEN_WIDTH cannot hold MASK_WIDTH");
  end
  if (MATCH_LEN_WIDTH < $clog2(MAX_MATCH_LEN + 1)) begin : g_len_width_check
    $error("MATCH_LEN_WIDTH cannot hold MAX_MATCH_LEN");
  end

  localparam int SUM_W = MATCH_LEN_WIDTH + 1;
  localparam logic [SUM_W-1:0] c_max = SUM_W'(MAX_MATCH_LEN);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                     r_state;
  logic [MATCH_LEN_WIDTH-1:0] r_acc;
  logic [MATCH_LEN_WIDTH-1:0] r_out_len;
  logic [ID_WIDTH-1:0]        r_id;

  logic                       w_abort;
  logic                       w_start_fire;
  logic                       w_seg_fire;
  logic [SUM_W-1:0]           w_sum;
  logic                       w_sat;
  logic                       w_stop;
  logic [MATCH_LEN_WIDTH-1:0] w_final;

`ifdef MATCH_LEN_EXT_ABORT_EN
  assign w_abort = abort & (r_state == S_ACCUM);
`else
  assign w_abort = 1'b0;
`endif

  assign bus.start_ready   = (r_state == S_IDLE) | ((r_state == S_DONE) & bus.out_ready);
  // An abort cycle closes the candidate, so no window is taken alongside it.
  assign bus.seg_ready     = (r_state == S_ACCUM) & ~w_abort;
  assign bus.out_valid     = (r_state == S_DONE);
  assign bus.out_id        = r_id;
  assign bus.out_match_len = r_out_len;

  assign w_start_fire = bus.start_valid & bus.start_ready;
  assign w_seg_fire   = bus.seg_valid & bus.seg_ready;

  assign w_sum   = {1'b0, r_acc} + {{(SUM_W - SEG_LEN_WIDTH){1'b0}}, bus.seg_len};
  assign w_sat   = (w_sum >= c_max);
  assign w_stop  = ~bus.seg_can_ext | w_sat;
  assign w_final = w_sat ? c_max[MATCH_LEN_WIDTH-1:0] : w_sum[MATCH_LEN_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_acc     <= '0;
      r_out_len <= '0;
      r_id      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_fire) begin
            r_id    <= bus.start_id;
            r_acc   <= '0;
            r_state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (w_abort) begin
            r_out_len <= r_acc;
            r_state   <= S_DONE;
          end else if (w_seg_fire) begin
            if (w_stop) begin
              r_out_len <= w_final;
              r_state   <= S_DONE;
            end else begin
              r_acc <= w_sum[MATCH_LEN_WIDTH-1:0];
            end
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            if (bus.start_valid) begin
              r_id    <= bus.start_id;
              r_acc   <= '0;
              r_state <= S_ACCUM;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_match_len_extender.sv
`default_nettype none
// tb_match_len_extender : directed stimulus with a queue-based result scoreboard.
module tb_match_len_extender;

  localparam int IDW = 6;
  localparam int SLW = 5;
  localparam int MLW = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
`ifdef MATCH_LEN_EXT_ABORT_EN
  logic abort = 1'b0;
`endif

  always #5 clk = ~clk;

  match_len_extender_if #(.ID_WIDTH(IDW), .SEG_LEN_WIDTH(SLW), .MATCH_LEN_WIDTH(MLW)) bus ();

  match_len_extender #(
    .MASK_WIDTH(14), .SEG_LEN_WIDTH(SLW), .MAX_MATCH_LEN(258),
    .MATCH_LEN_WIDTH(MLW), .ID_WIDTH(IDW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef MATCH_LEN_EXT_ABORT_EN
    .abort (abort),
`endif
    .bus   (bus)
  );

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [MLW-1:0] len;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   seg_hs  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Scoreboard monitor: every retired result is matched against the queue head.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_id", int'(bus.out_id), int'(e.id));
        chk("out_match_len", int'(bus.out_match_len), int'(e.len));
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n && bus.seg_valid && bus.seg_ready) seg_hs++;
  end

  task automatic do_start(input int id);
    int n = 0;
    bus.start_valid = 1'b1;
    bus.start_id    = IDW'(id);
    @(negedge clk);
    while (!bus.start_ready && n < 50) begin @(negedge clk); n++; end
    if (!bus.start_ready) chk("start_timeout", 0, 1);
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
  endtask

  task automatic do_seg(input int len, input bit ext);
    int n = 0;
    bus.seg_valid   = 1'b1;
    bus.seg_len     = SLW'(len);
    bus.seg_can_ext = ext;
    @(negedge clk);
    while (!bus.seg_ready && n < 50) begin @(negedge clk); n++; end
    if (!bus.seg_ready) chk("seg_timeout", 0, 1);
    @(posedge clk); #1;
    bus.seg_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin @(negedge clk); n++; end
    chk("drain", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic push(input int id, input int len);
    exp_t e;
    e.id  = IDW'(id);
    e.len = MLW'(len);
    exp_q.push_back(e);
  endtask

  initial begin
    bus.start_valid = 1'b0;
    bus.start_id    = '0;
    bus.seg_valid   = 1'b0;
    bus.seg_len     = '0;
    bus.seg_can_ext = 1'b0;
    bus.out_ready   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_len", int'(bus.out_match_len), 0);
    chk("rst_out_id", int'(bus.out_id), 0);
    chk("rst_start_ready", int'(bus.start_ready), 1);
    chk("rst_seg_ready", int'(bus.seg_ready), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single window with one-cycle result latency
    push(5, 7);
    do_start(5);
    do_seg(7, 1'b0);
    @(negedge clk);
    chk("latency_out_valid", int'(bus.out_valid), 1);
    wait_drain();

    // Multi-window
    seg_hs = 0;
    push(1, 31);
    do_start(1);
    do_seg(14, 1'b1);
    do_seg(14, 1'b1);
    do_seg(3, 1'b0);
    wait_drain();
    chk("multi_seg_hs", seg_hs, 3);

    // Saturation under backpressure, then back-to-back start
    seg_hs = 0;
    bus.out_ready = 1'b0;
    push(2, 258);
    do_start(2);
    for (int i = 0; i < 19; i++) do_seg(14, 1'b1);
    bus.seg_valid   = 1'b1;
    bus.seg_len     = SLW'(14);
    bus.seg_can_ext = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", int'(bus.out_valid), 1);
      chk("bp_out_len", int'(bus.out_match_len), 258);
      chk("bp_start_ready", int'(bus.start_ready), 0);
      chk("bp_seg_ready", int'(bus.seg_ready), 0);
      @(posedge clk); #1;
    end
    chk("sat_seg_hs", seg_hs, 19);
    bus.seg_valid   = 1'b0;
    bus.out_ready   = 1'b1;
    bus.start_valid = 1'b1;
    bus.start_id    = IDW'(9);
    @(negedge clk);
    chk("b2b_start_ready", int'(bus.start_ready), 1);
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    @(negedge clk);
    chk("b2b_out_valid", int'(bus.out_valid), 0);
    chk("b2b_seg_ready", int'(bus.seg_ready), 1);
    chk("b2b_queue", exp_q.size(), 0);
    push(9, 5);
    @(posedge clk); #1;
    do_seg(5, 1'b0);
    wait_drain();

    // Reset in the middle of a candidate
    do_start(3);
    do_seg(14, 1'b1);
    do_seg(14, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", int'(bus.out_valid), 0);
    chk("mid_rst_out_len", int'(bus.out_match_len), 0);
    chk("mid_rst_start_ready", int'(bus.start_ready), 1);
    @(posedge clk); #1;
    push(4, 4);
    do_start(4);
    do_seg(4, 1'b0);
    wait_drain();

    // Zero-length match and short-but-extendable window
    push(7, 0);
    do_start(7);
    do_seg(0, 1'b0);
    wait_drain();
    push(8, 8);
    do_start(8);
    do_seg(5, 1'b1);
    do_seg(3, 1'b0);
    wait_drain();

`ifdef MATCH_LEN_EXT_ABORT_EN
    seg_hs = 0;
    push(10, 28);
    do_start(10);
    do_seg(14, 1'b1);
    do_seg(14, 1'b1);
    bus.seg_valid   = 1'b1;
    bus.seg_len     = SLW'(14);
    bus.seg_can_ext = 1'b1;
    abort           = 1'b1;
    @(negedge clk);
    chk("abort_seg_ready", int'(bus.seg_ready), 0);
    @(posedge clk); #1;
    abort         = 1'b0;
    bus.seg_valid = 1'b0;
    wait_drain();
    chk("abort_seg_hs", seg_hs, 2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/match_len_extender.md
Name: match_len_extender

Overview:
- Sits directly downstream of the per-window match-length encoder.
- Takes a stream of per-window results (segment length plus can-extend flag) for one candidate match and accumulates them into a total match length.
- Stops on the first non-extendable window or when the length reaches MAX_MATCH_LEN.
- Hands the final length, tagged with the candidate ID, to the sequence-emit stage over a valid/ready handshake.

Parameters:
- MASK_WIDTH, 14: bytes compared per window; the largest legal seg_len.
- SEG_LEN_WIDTH, 5: width of seg_len; must hold MASK_WIDTH.
- MAX_MATCH_LEN, 258: saturation limit for the total match length.
- MATCH_LEN_WIDTH, 9: width of out_match_len; must hold MAX_MATCH_LEN.
- ID_WIDTH, 6: width of the candidate tag.

Ports:
- clk  input  1  clock; one clock domain; all logic on the rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- start_valid  input  1  a new candidate begins.
- start_ready  output  1  the block can accept a new candidate.
- start_id  input  ID_WIDTH  candidate tag.
- seg_valid  input  1  a window result is present.
- seg_ready  output  1  the block accepts a window result.
- seg_len  input  SEG_LEN_WIDTH  matched bytes in this window (0..MASK_WIDTH).
- seg_can_ext  input  1  the whole window matched, so the match may continue.
- out_valid  output  1  the final result is present.
- out_ready  input  1  downstream accepts the result.
- out_id  output  ID_WIDTH  tag of the finished candidate.
- out_match_len  output  MATCH_LEN_WIDTH  final accumulated length.

Behaviour:
- States: IDLE, ACCUM, DONE. One candidate is in flight at a time.
- Reset (rst_n=0 at a clk edge): state goes to IDLE; acc, out_id and out_match_len go to 0; out_valid goes to 0. This applies from any state, including mid-ACCUM; the partial candidate is discarded.
- start_ready = (state==IDLE) | (state==DONE & out_ready).
- seg_ready = (state==ACCUM).
- out_valid = (state==DONE).
- All outputs are registered or decoded from state only. There is no combinational path from seg_* to out_*.
- Start handshake (start_valid & start_ready): latch start_id, set acc=0, next state ACCUM.
- Segment handshake in ACCUM:
  - sum = acc + seg_len, computed at MATCH_LEN_WIDTH+1 bits.
  - If seg_can_ext=0 or sum >= MAX_MATCH_LEN: out_match_len = min(sum, MAX_MATCH_LEN), next state DONE.
  - Otherwise acc = sum and the block stays in ACCUM.
- Latency: out_valid rises on the cycle after the final segment handshake.
- DONE: out_id and out_match_len stay stable while out_valid=1 and out_ready=0.
  - On out_ready=1 with no start handshake: next state IDLE.
  - On out_ready=1 together with a start handshake in the same cycle: next state ACCUM and the new id is latched. Candidates run back-to-back with no bubble.
- Segments presented outside ACCUM are not accepted: seg_ready=0 and the data is ignored.
- seg_len is used as given. seg_can_ext=1 with seg_len<MASK_WIDTH is a protocol violation upstream; the block still accumulates and continues.
- A first segment of (0, can_ext=0) yields out_match_len=0, which is legal.
- Saturation takes priority over can_ext: reaching MAX_MATCH_LEN ends the candidate even when seg_can_ext=1.

Optional Feature:
- Macro MATCH_LEN_EXT_ABORT_EN.
- When defined, the block adds an input port abort (1 bit).
  - abort=1 in ACCUM forces next state DONE with out_match_len = acc. Any segment handshake in that same cycle is excluded, so seg_ready=0 that cycle.
  - abort is ignored in IDLE and DONE.
- When undefined, the port does not exist and the behaviour is exactly as above.

Test Plan:
- Single window: start id=5, seg (7,0) -> out_valid on the next cycle, out_id=5, out_match_len=7.
- Multi-window: start id=1, segs (14,1),(14,1),(3,0) -> out_match_len=31; seg_ready is high for exactly these 3 handshakes.
- Saturation: 19 segs of (14,1) -> after 18 segs acc=252; the 19th gives 266, clamped -> out_match_len=258, state DONE, seg_ready=0 despite can_ext=1.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 5 cycles -> out_valid=1, out_match_len stable, start_ready=0, seg_ready=0.
  - Then assert out_ready with start_valid and id=9 in the same cycle -> out retires and the block is in ACCUM with id 9 on the next cycle.
- Reset mid-operation: rst_n=0 for 1 cycle after 2 segs (14,1) -> out_valid=0, out_match_len=0, start_ready=1. A new candidate with seg (4,0) then gives 4, not 32.
- With MATCH_LEN_EXT_ABORT_EN: segs (14,1),(14,1), then abort=1 while seg_valid=1 -> out_match_len=28 and the third segment is not accepted.
